// File: rtl/seven_segment_scan_controller.sv
// Round-robin scan controller for a multiplexed BCD seven-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses digit enables for leading zeros.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// ST_BLANK | anti-ghosting gap at slot start; all digit enables low
// ST_DRIVE | current digit enabled (unless invalid or leading-zero blanked)
module seven_segment_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] display, display_nxt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pending, pending_nxt;
    logic                    accept, commit;
    logic [3:0]              digit_nxt;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   en_nxt;

    // Slot sequencing: cnt spans the whole slot, blank portion first.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        wrap      = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (cnt == SLOT_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    assign accept      = load_valid && load_ready;
    assign commit      = wrap && pending;
    assign pending_nxt = (pending && !commit) || accept;
    assign display_nxt = commit ? shadow : display;

    always_comb begin
        digit_nxt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) digit_nxt = display_nxt[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_seen;
    // Digit 0 is never blanked so an all-zero image still shows "0".
    always_comb begin
        lz_blank = '0;
        lz_seen  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (display_nxt[4*i +: 4] != 4'd0) lz_seen = 1'b1;
            lz_blank[i] = !lz_seen;
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        en_nxt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(i))
                en_nxt[i] = (state_nxt == ST_DRIVE) && (digit_nxt <= 4'd9) && !lz_blank[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            display    <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            bcd        <= '0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            display    <= display_nxt;
            pending    <= pending_nxt;
            load_ready <= !pending_nxt;
            if (accept) shadow <= load_data;
            // bcd only moves on slot entry, while every enable is low.
            if (state_nxt == ST_BLANK && cnt_nxt == '0) bcd <= digit_nxt;
            digit_en   <= en_nxt;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Self-checking bench: frame-arithmetic reference model plus directed literal checks.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seven_segment_scan_controller;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [15:0]   load_data = 16'h0000;
    logic [3:0]    bcd;
    logic [ND-1:0] digit_en;
    logic          frame_done;

    seven_segment_scan_controller #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .bcd       (bcd),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_t      = 0;
    logic        m_pend   = 1'b0;
    logic [15:0] m_disp   = '0;
    logic [15:0] m_shadow = '0;
    logic        started  = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (model t=%0d)", nm, act, exp, m_t);
        end
    endtask

    function automatic logic [ND-1:0] exp_en(input int t, input logic [15:0] img);
        int pos, idx, hi;
        logic [3:0] d;
        logic [ND-1:0] en;
        pos = t % RD;
        idx = (t / RD) % ND;
        d   = img[idx*4 +: 4];
        en  = '0;
        if (pos >= BC && d <= 4'd9) begin
            en[idx] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            hi = 0;
            for (int i = 0; i < ND; i++) if (img[i*4 +: 4] != 4'd0) hi = i;
            if (idx > hi) en = '0;
`else
            hi = 0;
`endif
        end
        return en;
    endfunction

    // Reference model: position derived from cycles since reset; image swaps at frame boundaries.
    initial begin
        logic acc;
        int   idx;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_t = 0; m_pend = 1'b0; m_disp = '0; m_shadow = '0; started = 1'b1;
            end else if (started) begin
                acc = load_valid && !m_pend;
                m_t++;
                if (m_t % FRAME == 0 && m_pend) begin
                    m_disp = m_shadow;
                    m_pend = 1'b0;
                end
                if (acc) begin
                    m_shadow = load_data;
                    m_pend   = 1'b1;
                end
            end
            @(negedge clk);
            if (started) begin
                idx = (m_t / RD) % ND;
                chk("bcd", 16'(bcd), 16'(m_disp[idx*4 +: 4]));
                chk("digit_en", 16'(digit_en), 16'(exp_en(m_t, m_disp)));
                chk("frame_done", 16'(frame_done), 16'(m_t != 0 && m_t % FRAME == 0));
                chk("load_ready", 16'(load_ready), 16'(!m_pend));
            end
        end
    end

    task automatic goto(input int tt);
        int n;
        n = 0;
        while (m_t != tt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (m_t != tt) begin
            n_fail++;
            $display("FAIL goto: reached t=%0d required t=%0d", m_t, tt);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_en", 16'(digit_en), 16'h0);
        chk("rst_bcd", 16'(bcd), 16'h0);
        chk("rst_ready", 16'(load_ready), 16'h1);
        chk("rst_fd", 16'(frame_done), 16'h0);
        rst = 1'b0;

        goto(1);   chk("t1_en", 16'(digit_en), 16'h0);
        goto(2);   chk("t2_en", 16'(digit_en), 16'h1);
        goto(7);   chk("t7_en", 16'(digit_en), 16'h1);
        goto(8);   chk("t8_en", 16'(digit_en), 16'h0);

        goto(10);  load_valid = 1'b1; load_data = 16'h1234;
        goto(11);  load_valid = 1'b0; chk("ld_ready_low", 16'(load_ready), 16'h0);
        goto(18);  chk("mid_bcd", 16'(bcd), 16'h0);
        goto(32);  chk("wrap_fd", 16'(frame_done), 16'h1);
                   chk("wrap_bcd", 16'(bcd), 16'h4);
                   chk("wrap_ready", 16'(load_ready), 16'h1);
        goto(33);  chk("fd_width", 16'(frame_done), 16'h0);
        goto(34);  chk("d0_bcd", 16'(bcd), 16'h4); chk("d0_en", 16'(digit_en), 16'h1);
        goto(42);  chk("d1_bcd", 16'(bcd), 16'h3); chk("d1_en", 16'(digit_en), 16'h2);
        goto(50);  chk("d2_bcd", 16'(bcd), 16'h2); chk("d2_en", 16'(digit_en), 16'h4);
        goto(58);  chk("d3_bcd", 16'(bcd), 16'h1); chk("d3_en", 16'(digit_en), 16'h8);

        goto(60);  load_valid = 1'b1; load_data = 16'hAAAA;
        goto(61);  load_data = 16'h5678;
        goto(62);  chk("held_ready", 16'(load_ready), 16'h0);
        goto(64);  chk("ready_back", 16'(load_ready), 16'h1);
        goto(65);  load_valid = 1'b0;
        goto(66);  chk("inv_bcd", 16'(bcd), 16'hA); chk("inv_en", 16'(digit_en), 16'h0);
        goto(98);  chk("img2_bcd", 16'(bcd), 16'h8); chk("img2_en", 16'(digit_en), 16'h1);

        goto(127); load_valid = 1'b1; load_data = 16'h0050;
        goto(128); load_valid = 1'b0;
                   chk("wrapacc_ready", 16'(load_ready), 16'h0);
        goto(130); chk("nobypass_bcd", 16'(bcd), 16'h8);
        goto(140); load_valid = 1'b1; load_data = 16'h9999;
        goto(150); load_valid = 1'b0; load_data = 16'h0000;
        goto(162); chk("z_bcd", 16'(bcd), 16'h0); chk("z_en", 16'(digit_en), 16'h1);
        goto(170); load_valid = 1'b1; load_data = 16'h0000;
                   chk("d1_5_bcd", 16'(bcd), 16'h5); chk("d1_5_en", 16'(digit_en), 16'h2);
        goto(171); load_valid = 1'b0;
        goto(178); chk("lz2_bcd", 16'(bcd), 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
                   chk("lz2_en", 16'(digit_en), 16'h0);
`else
                   chk("lz2_en", 16'(digit_en), 16'h4);
`endif
        goto(200); load_valid = 1'b1; load_data = 16'h4321;
        goto(201); load_valid = 1'b0;
        goto(205); rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_en", 16'(digit_en), 16'h0);
        chk("mrst_bcd", 16'(bcd), 16'h0);
        chk("mrst_ready", 16'(load_ready), 16'h1);
        chk("mrst_fd", 16'(frame_done), 16'h0);
        rst = 1'b0;
        goto(2);   chk("rs_en", 16'(digit_en), 16'h1);
        goto(32);  chk("rs_fd", 16'(frame_done), 16'h1);
        goto(34);  chk("lost_bcd", 16'(bcd), 16'h0); chk("lost_en", 16'(digit_en), 16'h1);
        goto(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
